bus_sequencer: RTL and testbench

Central bus-transfer controller for the shared 16-bit tristate data bus. Accepts queued move requests (source register → destination register, or immediate → register, or register → host) and sequences the per-register `enable` (drive bus) and `latch` (capture bus) strobes so exactly one driver is active per transfer. It is the control end of the bus register interface: every bus register's `latch`/`enable` inputs are driven from this block's one-hot outputs. It sits between the instruction decode/control path and the register file.

---
 rtl/bus_seq_pkg.sv | 22 ++
 rtl/bus_seq_if.sv | 28 ++
 rtl/bus_seq_fifo.sv | 51 +++++
 rtl/bus_sequencer.sv | 75 +++++++
 tb/tb_bus_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: shared sizes, FSM state and request record for the bus sequencer.
package bus_seq_pkg;
    localparam int NUM_REGS = 8;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
        logic             imm_en;
        logic [WIDTH-1:0] imm;
        logic             dst_host;
    } req_t;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction
endpackage

// File: rtl/bus_seq_if.sv
// bus_seq_if: request handshake, register strobes, status and host read-back of the bus sequencer.
//   master : request side (decode/control path and register file)
//   slave  : the sequencer itself
interface bus_seq_if;
    import bus_seq_pkg::*;
    logic                req_valid;
    logic                req_ready;
    logic [IDX_W-1:0]    req_src;
    logic [IDX_W-1:0]    req_dst;
    logic                req_imm_en;
    logic [WIDTH-1:0]    req_imm;
    logic                req_dst_host;
    logic [NUM_REGS-1:0] enable;
    logic [NUM_REGS-1:0] latch;
    logic                busy;
    logic                xfer_done;
    logic                rd_valid;
    logic [WIDTH-1:0]    rd_data;

    modport master (
        output req_valid, req_src, req_dst, req_imm_en, req_imm, req_dst_host,
        input  req_ready, enable, latch, busy, xfer_done, rd_valid, rd_data
    );
    modport slave (
        input  req_valid, req_src, req_dst, req_imm_en, req_imm, req_dst_host,
        output req_ready, enable, latch, busy, xfer_done, rd_valid, rd_data
    );
endinterface

// File: rtl/bus_seq_fifo.sv
// bus_seq_fifo: synchronous request FIFO of DEPTH entries.
//   clk, reset       : clock, synchronous active-high reset (flushes contents)
//   push_i, din_i    : write request (ignored when full)
//   pop_i, dout_o    : read request (ignored when empty), head entry
//   full_o, empty_o, count_o : occupancy from registered count
module bus_seq_fifo
    import bus_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  req_t             din_i,
    output req_t             dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = count_q == CNT_W'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push)
                wr_q <= wr_q + PTR_W'(1);
            if (do_pop)
                rd_q <= rd_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: sequences one-hot enable/latch strobes for queued bus moves.
//   clk, reset : clock, synchronous active-high reset
//   sif        : request handshake, strobes, busy/xfer_done, host read-back (slave side)
//   DATA       : shared tristate bus, driven here only during immediate transfers
module bus_sequencer
    import bus_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    bus_seq_if.slave         sif,
    inout  wire  [WIDTH-1:0] DATA
);
    state_t           state_q, state_d;
    req_t             cur_q, cur_d, head, req;
    logic             full, empty, push, pop, active, host_cap;
    logic [CNT_W-1:0] count;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    assign req  = {sif.req_src, sif.req_dst, sif.req_imm_en, sif.req_imm, sif.req_dst_host};
    assign push = sif.req_valid && sif.req_ready;

    bus_seq_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (req),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // Popping from LATCH as well as IDLE lets a queued move go straight to DRIVE.
    always_comb begin
        pop     = !empty && state_q != DRIVE;
        cur_d   = pop ? head : cur_q;
        state_d = pop ? DRIVE : (state_q == DRIVE ? LATCH : IDLE);
    end

    assign active   = state_q != IDLE;
    assign host_cap = state_q == LATCH && cur_q.dst_host;

    // Source keeps driving through LATCH so the destination captures a stable bus.
    assign sif.enable    = (active && !cur_q.imm_en) ? onehot(cur_q.src) : '0;
    assign sif.latch     = (state_q == LATCH && !cur_q.dst_host && !reset) ? onehot(cur_q.dst) : '0;
    assign sif.xfer_done = state_q == LATCH;
    assign sif.busy      = count != '0 || active;
    assign sif.req_ready = !full;
    assign sif.rd_valid  = rd_valid_q;
    assign sif.rd_data   = rd_data_q;
    assign DATA          = (active && cur_q.imm_en) ? cur_q.imm : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= host_cap;
            if (host_cap)
                rd_data_q <= cur_q.imm_en ? cur_q.imm : DATA;
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed and random checks of bus_sequencer against a transfer-timeline model.
module tb_bus_sequencer;
    import bus_seq_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    wire [WIDTH-1:0] DATA;

    bus_seq_if sif();

    bus_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif),
        .DATA  (DATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] src;
        logic [IDX_W-1:0] dst;
        logic             imm_en;
        logic [WIDTH-1:0] imm;
        logic             host;
        int               drive;
    } xf_t;

    xf_t  sched[$];
    int   cyc = 0, last_latch = -10, rdv_at = -10;
    int   tot = 0, bad = 0, done_cnt = 0, low_cnt = 0;
    logic started = 1'b0;
    logic [WIDTH-1:0] exp_rd = '0;
    logic [WIDTH-1:0] regs     [NUM_REGS] = '{16'h1000, 16'h1111, 16'h2222, 16'h1234, 16'h4444, 16'h5555, 16'h6666, 16'h00FF};
    logic [WIDTH-1:0] exp_regs [NUM_REGS] = '{16'h1000, 16'h1111, 16'h2222, 16'h1234, 16'h4444, 16'h5555, 16'h6666, 16'h00FF};
    logic             ben;
    logic [WIDTH-1:0] bdrv;

    // Bench-side register file: drives the bus on enable, captures it on latch.
    always_comb begin
        ben  = 1'b0;
        bdrv = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sif.enable[i]) begin
                ben  = 1'b1;
                bdrv = regs[i];
            end
    end
    assign DATA = ben ? bdrv : 16'hzzzz;

    always @(posedge clk)
        for (int i = 0; i < NUM_REGS; i++)
            if (sif.latch[i])
                regs[i] <= DATA;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Timeline model: a move accepted at edge N drives in the period after edge
    // max(N+1, previous latch period + 1) and latches in the period after that.
    always @(posedge clk) begin : model
        xf_t x;
        int  d, pend;
        cyc++;
        if (reset) begin
            sched.delete();
            last_latch = -10;
            rdv_at     = -10;
            exp_rd     = '0;
        end else begin
            if (sched.size() > 0 && sched[0].drive + 1 == cyc - 1) begin
                x = sched.pop_front();
                if (x.host) begin
                    exp_rd = x.imm_en ? x.imm : exp_regs[x.src];
                    rdv_at = cyc;
                end else
                    exp_regs[x.dst] = x.imm_en ? x.imm : exp_regs[x.src];
            end
            pend = 0;
            foreach (sched[i]) if (sched[i].drive > cyc - 1) pend++;
            if (sif.req_valid && pend < DEPTH) begin
                d        = (cyc + 1 > last_latch + 1) ? cyc + 1 : last_latch + 1;
                x.src    = sif.req_src;
                x.dst    = sif.req_dst;
                x.imm_en = sif.req_imm_en;
                x.imm    = sif.req_imm;
                x.host   = sif.req_dst_host;
                x.drive  = d;
                sched.push_back(x);
                last_latch = d + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [NUM_REGS-1:0] ee, el;
        logic                ed, act, ia;
        logic [WIDTH-1:0]    iv;
        logic [127:0]        rv, ev;
        int                  pend;
        if (started && reset)
            check("latch_in_reset", sif.latch, 0);
        else if (started) begin
            ee = '0; el = '0; ed = 0; act = 0; ia = 0; iv = '0; pend = 0;
            foreach (sched[i]) begin
                if (sched[i].drive > cyc)
                    pend++;
                else if (sched[i].drive == cyc || sched[i].drive + 1 == cyc) begin
                    act = 1;
                    if (!sched[i].imm_en) ee = 8'b1 << sched[i].src;
                    else begin ia = 1; iv = sched[i].imm; end
                    if (sched[i].drive + 1 == cyc) begin
                        ed = 1;
                        if (!sched[i].host) el = 8'b1 << sched[i].dst;
                    end
                end
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                rv[i*16 +: 16] = regs[i];
                ev[i*16 +: 16] = exp_regs[i];
            end
            check("enable", sif.enable, ee);
            check("latch", sif.latch, el);
            check("xfer_done", sif.xfer_done, ed);
            check("busy", sif.busy, act || pend > 0);
            check("req_ready", sif.req_ready, pend < DEPTH);
            check("rd_valid", sif.rd_valid, rdv_at == cyc);
            check("rd_data", sif.rd_data, exp_rd);
            check("regs", rv, ev);
            check("onehot_enable", $onehot0(sif.enable), 1);
            check("onehot_latch", $onehot0(sif.latch), 1);
            if (ia) check("imm_on_bus", DATA, iv);
            if (sif.xfer_done) done_cnt++;
            if (!sif.req_ready) low_cnt++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int d, input bit ie, input logic [15:0] v, input bit h);
        bit acc = 0;
        sif.req_valid    = 1'b1;
        sif.req_src      = IDX_W'(s);
        sif.req_dst      = IDX_W'(d);
        sif.req_imm_en   = ie;
        sif.req_imm      = v;
        sif.req_dst_host = h;
        for (int w = 0; w < 40 && !acc; w++) begin
            acc = sif.req_ready;
            sync();
        end
        sif.req_valid = 1'b0;
        check("accept", acc, 1);
    endtask

    initial begin
        int e0, d0, l0;
        sif.req_valid = 0; sif.req_src = '0; sif.req_dst = '0;
        sif.req_imm_en = 0; sif.req_imm = '0; sif.req_dst_host = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_ready", sif.req_ready, 1);
        check("rst_enable", sif.enable, 0);
        check("rst_latch", sif.latch, 0);
        check("rst_busy", sif.busy, 0);
        check("rst_done", sif.xfer_done, 0);
        check("rst_rdv", sif.rd_valid, 0);
        check("rst_rdd", sif.rd_data, 0);

        // register 3 -> register 5
        sync(); send(3, 5, 0, 0, 0);
        @(negedge clk); check("t1_wait_en", sif.enable, 0); check("t1_busy", sif.busy, 1);
        @(negedge clk); check("t1_drive_en", sif.enable, 8'h08); check("t1_drive_lat", sif.latch, 0);
        @(negedge clk); check("t1_latch_en", sif.enable, 8'h08); check("t1_latch_lat", sif.latch, 8'h20);
        check("t1_done", sif.xfer_done, 1);
        @(negedge clk); check("t1_reg5", regs[5], 16'h1234); check("t1_idle", sif.busy, 0);

        // immediate -> register 2
        sync(); send(0, 2, 1, 16'hBEEF, 0);
        @(negedge clk);
        @(negedge clk); check("t2_drive_bus", DATA, 16'hBEEF); check("t2_drive_en", sif.enable, 0);
        @(negedge clk); check("t2_latch_bus", DATA, 16'hBEEF); check("t2_latch_lat", sif.latch, 8'h04);
        check("t2_latch_en", sif.enable, 0);
        @(negedge clk); check("t2_reg2", regs[2], 16'hBEEF);

        // ten back-to-back moves whose results depend on ordering
        sync();
        d0 = done_cnt; l0 = low_cnt;
        send(0, 0, 1, 16'h0001, 0);
        e0 = cyc;
        send(0, 1, 0, 0, 0);
        send(0, 0, 1, 16'h0002, 0);
        send(0, 6, 0, 0, 0);
        send(0, 1, 1, 16'hA5A5, 0);
        send(1, 4, 0, 0, 0);
        send(6, 1, 0, 0, 0);
        send(2, 0, 0, 0, 0);
        send(5, 5, 0, 0, 0);
        send(0, 0, 0, 0, 1);
        for (int w = 0; w < 60 && sif.busy; w++) @(negedge clk);
        check("t3_busy_fall", cyc - e0, 21);
        check("t3_done_cnt", done_cnt - d0, 10);
        check("t3_ready_low", low_cnt - l0, 4);
        check("t3_r0", regs[0], 16'hBEEF);
        check("t3_r1", regs[1], 16'h0002);
        check("t3_r4", regs[4], 16'hA5A5);
        check("t3_r6", regs[6], 16'h0002);
        check("t3_rd", sif.rd_data, 16'hBEEF);

        // host read of register 7
        sync(); send(7, 0, 0, 0, 1);
        @(negedge clk);
        @(negedge clk); check("t4_drive_en", sif.enable, 8'h80);
        @(negedge clk); check("t4_latch_lat", sif.latch, 0); check("t4_rdv_early", sif.rd_valid, 0);
        @(negedge clk); check("t4_rdv", sif.rd_valid, 1); check("t4_rdd", sif.rd_data, 16'h00FF);
        @(negedge clk); check("t4_rdv_end", sif.rd_valid, 0);

        // reset during LATCH with two moves still queued
        sync();
        send(1, 4, 0, 0, 0);
        send(2, 3, 0, 0, 0);
        send(3, 6, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk); check("t5_latch_gated", sif.latch, 0);
        sync(); reset = 1'b0;
        @(negedge clk);
        check("t5_busy", sif.busy, 0);
        check("t5_ready", sif.req_ready, 1);
        check("t5_en", sif.enable, 0);
        check("t5_r4", regs[4], 16'hA5A5);
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        check("t5_quiet", done_cnt - d0, 0);

        // random stream, checked every cycle by the model
        sync();
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) sync();
            send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                 16'($urandom), $urandom_range(0, 4) == 0);
        end
        for (int w = 0; w < 100 && sif.busy; w++) @(negedge clk);
        check("t6_drain", sif.busy, 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
